// File: rtl/mux_serial_tx_if.sv
// Word-source handshake, mux data/select bus and serial line of mux_serial_tx.
// fsm_state mirrors the controller state register for observation only.
interface mux_serial_tx_if;
  logic       load;
  logic [7:0] din;
  logic       ready;
  logic       busy;
  logic [7:0] a;
  logic       s1;
  logic       s2;
  logic       s3;
  logic       y;
  logic       txd;
  logic       done;
  logic [2:0] fsm_state;

  // Handshake: a word is taken on any rising edge where load=1 and ready=1;
  // load while ready=0 is dropped, there is no back-pressure beyond ready.
  modport master (
    output load, din, y,
    input  ready, busy, a, s1, s2, s3, txd, done, fsm_state
  );

  modport slave (
    input  load, din, y,
    output ready, busy, a, s1, s2, s3, txd, done, fsm_state
  );
endinterface

// File: rtl/mux_serial_tx.sv
// Serializer controller for an external 8:1 bit-select mux: latches a word,
// steps the selects LSB first and frames the mux output with start/parity/stop.
module mux_serial_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b0
) (
  input logic clk,
  input logic rst,
  mux_serial_tx_if.slave bus
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    a_q;
  logic          par;
  logic          done_q;
  logic          txd_c;

  wire period_end = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= 3'd0;
      a_q    <= 8'h00;
      par    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load) begin
            a_q   <= bus.din;
            par   <= ^bus.din;
            cnt   <= '0;
            idx   <= 3'd0;
            state <= START;
          end
        end
        START: begin
          if (period_end) begin
            cnt   <= '0;
            idx   <= 3'd0;
            state <= DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (period_end) begin
            cnt <= '0;
            if (idx == 3'd7) begin
              // Index returns to 0 so the selects read 000 outside DATA.
              idx   <= 3'd0;
              state <= PARITY_EN ? PARITY : STOP;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PARITY: begin
          if (period_end) begin
            cnt   <= '0;
            state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (period_end) begin
            cnt    <= '0;
            done_q <= 1'b1;
            state  <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          cnt   <= '0;
          idx   <= 3'd0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Data bits come straight through the external mux with no added latency.
  always_comb begin
    txd_c = 1'b1;
    case (state)
      START:   txd_c = 1'b0;
      DATA:    txd_c = bus.y;
      PARITY:  txd_c = par;
      default: txd_c = 1'b1;
    endcase
  end

  assign bus.txd       = txd_c;
  assign bus.a         = a_q;
  assign bus.s1        = idx[0];
  assign bus.s2        = idx[1];
  assign bus.s3        = idx[2];
  assign bus.done      = done_q;
  assign bus.ready     = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_mux_serial_tx.sv
// Bench for mux_serial_tx: three configurations share clk/rst, one is selected
// at a time; each cycle is compared against a frame-timing reference model.
module tb_mux_serial_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_serial_tx_if b0 ();
  mux_serial_tx_if b1 ();
  mux_serial_tx_if b2 ();

  mux_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  mux_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  mux_serial_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1'b0)) u2 (.clk(clk), .rst(rst), .bus(b2));

  // Behavioural 8:1 mux downstream of each controller.
  assign b0.y = b0.a[{b0.s3, b0.s2, b0.s1}];
  assign b1.y = b1.a[{b1.s3, b1.s2, b1.s1}];
  assign b2.y = b2.a[{b2.s3, b2.s2, b2.s1}];

  int         sel = 0;
  logic       load = 1'b0;
  logic [7:0] din = 8'h00;
  logic [14:0] obs;

  int n_of [3] = '{4, 4, 1};
  int p_of [3] = '{0, 1, 0};
  logic [7:0] last_a [3] = '{8'h00, 8'h00, 8'h00};

  always_comb begin
    b0.load = 1'b0; b1.load = 1'b0; b2.load = 1'b0;
    b0.din = din;   b1.din = din;   b2.din = din;
    case (sel)
      0:       b0.load = load;
      1:       b1.load = load;
      default: b2.load = load;
    endcase
  end

  // Observed vector: {txd, selects, done, ready, busy, a}
  always_comb begin
    case (sel)
      0:       obs = {b0.txd, b0.s3, b0.s2, b0.s1, b0.done, b0.ready, b0.busy, b0.a};
      1:       obs = {b1.txd, b1.s3, b1.s2, b1.s1, b1.done, b1.ready, b1.busy, b1.a};
      default: obs = {b2.txd, b2.s3, b2.s2, b2.s1, b2.done, b2.ready, b2.busy, b2.a};
    endcase
  end

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    else
      passed++;
  endtask

  function automatic logic [14:0] mk(input logic t, input logic [2:0] s, input logic d,
                                     input logic r, input logic [7:0] a);
    return {t, s, d, r, ~r, a};
  endfunction

  // Frame model: cycle c after acceptance lies in bit period k = (c-1)/n.
  function automatic logic model_txd(input int n, input int p, input logic [7:0] d,
                                     input logic par, input int c);
    int k;
    k = (c - 1) / n;
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (p != 0 && k == 9) return par;
    return 1'b1;
  endfunction

  function automatic logic [2:0] model_sel(input int n, input int c);
    int k;
    k = (c - 1) / n;
    if (k >= 1 && k <= 8) return 3'(k - 1);
    return 3'd0;
  endfunction

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_frame(input logic [7:0] d, input int exp_done, input logic exp_par,
                           input int glitch);
    int n, p;
    logic r;
    n = n_of[sel];
    p = p_of[sel];
    din  = d;
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    for (int c = 1; c <= exp_done; c++) begin
      @(negedge clk);
      r = (c == exp_done);
      check($sformatf("frame sel%0d d=%h c%0d", sel, d, c), 32'(obs),
            32'(mk(model_txd(n, p, d, exp_par, c), model_sel(n, c), r, r, d)));
      if (glitch != 0 && c == glitch) begin
        load = 1'b1;
        din  = 8'hFF;
      end else if (glitch != 0 && c == glitch + 1) begin
        load = 1'b0;
        din  = d;
      end
    end
    last_a[sel] = d;
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      check($sformatf("idle sel%0d", sel), 32'(obs), 32'(mk(1'b1, 3'd0, 1'b0, 1'b1, last_a[sel])));
    end
  endtask

  typedef struct {
    int         sel;
    logic [7:0] din;
    int         exp_done;
    logic       exp_par;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 8'hA5, 41, 1'b0};
    tbl[1] = '{1, 8'hA5, 45, 1'b0};
    tbl[2] = '{1, 8'h07, 45, 1'b1};
    tbl[3] = '{2, 8'h80, 11, 1'b1};
    tbl[4] = '{2, 8'h00, 11, 1'b0};
    tbl[5] = '{0, 8'hFF, 41, 1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      sel = tbl[i].sel;
      idle_cycles(2);
      run_frame(tbl[i].din, tbl[i].exp_done, tbl[i].exp_par, 0);
    end

    // Mid-frame load ignored, then back-to-back load in the done cycle.
    sel = 0;
    idle_cycles(1);
    run_frame(8'h3C, 41, 1'b0, 10);
    run_frame(8'hFF, 41, 1'b0, 0);
    idle_cycles(1);

    // Reset/idle: reset mid-simulation, then 20 quiet cycles.
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_a[0] = 8'h00; last_a[1] = 8'h00; last_a[2] = 8'h00;
    check("state after reset", 32'({b0.fsm_state, b1.fsm_state, b2.fsm_state}), 32'(9'd0));
    idle_cycles(20);

    // Reset during data bit 3 of 8'h55 (cycles 17..20 with N=4).
    sel  = 0;
    din  = 8'h55;
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    repeat (18) @(negedge clk);
    check("bit3 before reset", 32'(obs), 32'(mk(1'b0, 3'd3, 1'b0, 1'b0, 8'h55)));
    rst = 1'b1;
    #1;
    check("async reset", 32'(obs), 32'(mk(1'b1, 3'd0, 1'b0, 1'b1, 8'h00)));
    @(negedge clk);
    rst = 1'b0;
    last_a[0] = 8'h00; last_a[1] = 8'h00; last_a[2] = 8'h00;
    idle_cycles(8);
    run_frame(8'h01, 41, 1'b1, 0);

    // Randomized frames against the model, idle gaps of 0..2 cycles.
    for (int i = 0; i < 24; i++) begin
      logic [7:0] d;
      sel = $urandom_range(0, 2);
      d   = 8'($urandom);
      idle_cycles($urandom_range(0, 2));
      run_frame(d, (10 + p_of[sel]) * n_of[sel] + 1, ^d, 0);
    end
    idle_cycles(2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
